// File: rtl/array_pack_seq.sv
// Collects WIDTH-bit elements into a LEN-element packed array and presents it with valid/ready.
// Optional early-close input `flush` is enabled by defining ARRAY_PACK_SEQ_FLUSH_EN.
module array_pack_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*LEN-1:0]       out_data,
  output logic [$clog2(LEN+1)-1:0]   out_count
`ifdef ARRAY_PACK_SEQ_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int unsigned CW = $clog2(LEN + 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] slots_q [LEN];
  logic [WIDTH-1:0] slots_d [LEN];
  logic             accept;
  logic             flush_req;

`ifdef ARRAY_PACK_SEQ_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Held in reset, in_ready stays low; in HOLD it mirrors out_ready so a new
  // element can land in slot 0 on the same edge the held array is consumed.
  assign in_ready  = rst_n & ((state_q == FILL) | out_ready);
  assign out_valid = (state_q == HOLD);
  // In HOLD idx_q carries the element count of the presented array.
  assign out_count = idx_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slots_d = slots_q;
    if (state_q == FILL) begin
      if (accept) begin
        for (int unsigned i = 0; i < LEN; i++) begin
          if (idx_q == CW'(i)) slots_d[i] = in_data;
        end
        idx_d = idx_q + CW'(1);
        if (idx_q == LAST_IDX) state_d = HOLD;
      end
      if (flush_req && (accept || (idx_q != '0))) state_d = HOLD;
    end else begin
      if (out_ready) begin
        for (int unsigned i = 0; i < LEN; i++) slots_d[i] = '0;
        idx_d   = '0;
        state_d = FILL;
        if (accept) begin
          slots_d[0] = in_data;
          idx_d      = CW'(1);
          if (LEN == 1) state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      for (int unsigned i = 0; i < LEN; i++) slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slots_q <= slots_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < LEN; i++) out_data[WIDTH*i +: WIDTH] = slots_q[i];
  end

endmodule

// File: tb/tb_array_pack_seq.sv
// Scoreboard bench for array_pack_seq (WIDTH=8, LEN=4): queue-based reference model plus
// a negedge monitor. Flush scenarios are exercised when ARRAY_PACK_SEQ_FLUSH_EN is defined.
module tb_array_pack_seq;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush_s = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W*L-1:0] out_data;
  logic [2:0]   out_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_arrays = 0;
  logic [31:0] last_pop = '0;
  int          last_cnt = 0;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } arr_t;

  arr_t         exp_q[$];
  logic [W-1:0] part[$];
  bit           m_held = 1'b0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  array_pack_seq #(.WIDTH(W), .LEN(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef ARRAY_PACK_SEQ_FLUSH_EN
    ,
    .flush     (flush_s)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_part();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < part.size(); i++) v[8*i +: 8] = part[i];
    return v;
  endfunction

  function automatic void close_array();
    arr_t a;
    a.data = pack_part();
    a.cnt  = part.size();
    exp_q.push_back(a);
    part.delete();
    m_held = 1'b1;
    m_cnt  = a.cnt;
  endfunction

  // Reference model: elements accumulate in a queue; every LEN elements (or a flush)
  // produce one expected array.
  initial begin
    bit held_b;
    bit acc;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        part.delete();
        exp_q.delete();
        m_held = 1'b0;
        m_cnt  = 0;
      end else begin
        held_b = m_held;
        acc    = in_valid && (!m_held || out_ready);
        if (m_held && out_ready) m_held = 1'b0;
        if (acc) begin
          part.push_back(in_data);
          if (part.size() == L) close_array();
        end
        if (flush_s && !held_b && !m_held && part.size() > 0) close_array();
      end
    end
  end

  // Monitor
  initial begin
    bit          have_prev;
    logic [31:0] prev_data;
    arr_t        a;
    have_prev = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_data", out_data, 0);
        have_prev = 1'b0;
      end else begin
        chk("out_valid", out_valid, m_held);
        chk("in_ready", in_ready, (!m_held || out_ready));
        chk("out_count", out_count, m_held ? m_cnt : part.size());
        if (!m_held) chk("fill_data", out_data, pack_part());
        if (have_prev && out_valid) chk("hold_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          chk("exp_avail", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            chk("pop_data", out_data, a.data);
            chk("pop_count", out_count, a.cnt);
            last_pop = out_data;
            last_cnt = int'(out_count);
            n_arrays++;
          end
          have_prev = 1'b0;
        end else if (out_valid) begin
          have_prev = 1'b1;
          prev_data = out_data;
        end else begin
          have_prev = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four back-to-back elements
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i * 17), 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("stream4_data", last_pop, 32'h44332211);
    chk("stream4_cnt", last_cnt, 4);

    // Hold with consumer stalled, then consume with a simultaneous accept
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'hB0 + i), 1'b0);
    repeat (5) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    chk("stall_pop", last_pop, 32'hB4B3B2B1);
    chk("slot0_cnt", out_count, 1);
    chk("slot0_data", out_data, 32'h00000055);
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(8'h55 + i), 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("after_stall", last_pop, 32'h58575655);

    // Twelve continuous elements
    base = n_arrays;
    for (int i = 1; i <= 12; i++) drive(1'b1, 8'(i), 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("cont_arrays", n_arrays - base, 3);
    chk("cont_last", last_pop, 32'h0C0B0A09);

    // Reset mid-array
    drive(1'b1, 8'h71, 1'b1);
    drive(1'b1, 8'h72, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", out_count, 0);
    drive(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    base = n_arrays;
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'hA0 + i), 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("post_rst_arrays", n_arrays - base, 1);
    chk("post_rst_data", last_pop, 32'hA4A3A2A1);

`ifdef ARRAY_PACK_SEQ_FLUSH_EN
    drive(1'b1, 8'hAA, 1'b1);
    drive(1'b1, 8'hBB, 1'b1);
    flush_s = 1'b1;
    drive(1'b0, '0, 1'b1);
    flush_s = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("flush_data", last_pop, 32'h0000BBAA);
    chk("flush_cnt", last_cnt, 2);
    flush_s = 1'b1;
    drive(1'b0, '0, 1'b1);
    flush_s = 1'b0;
    chk("flush_empty_valid", out_valid, 0);
`endif

    // Randomised handshakes
    for (int i = 0; i < 400; i++) begin
`ifdef ARRAY_PACK_SEQ_FLUSH_EN
      flush_s = ($urandom_range(0, 7) == 0);
`endif
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    flush_s = 1'b0;
    repeat (6) drive(1'b0, '0, 1'b1);
    chk("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
